rf_alu_sequencer: RTL and testbench

Multi-cycle operation sequencer that sits directly in front of the 8x32 register file and drives both of its ports. It accepts one instruction per start pulse (op, two source addresses, a destination, an immediate). It reads operands one at a time through the file's single read port, computes a 32-bit result, and writes it back through the write port. It is the block that feeds the register file's wAddr/wData/we and consumes its rData.

---
 rtl/rf_alu_sequencer.sv | 179 +++++++++++++++++
 tb/tb_rf_alu_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_alu_sequencer.sv
// Sequencer in front of the 8x32 register file: reads two operands through the
// single read port, runs one ALU op, and writes the result back through the write port.
module rf_alu_sequencer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [ADDR_W-1:0] src_a,
   input  logic [ADDR_W-1:0] src_b,
   input  logic [ADDR_W-1:0] dst,
   input  logic [DATA_W-1:0] imm,
   output logic [ADDR_W-1:0] rf_rAddr,
   input  logic [DATA_W-1:0] rf_rData,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wAddr,
   output logic [DATA_W-1:0] rf_wData,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              carry
);

   localparam int SH_W = $clog2(DATA_W);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRL = 3'b110;
   localparam logic [2:0] OP_LDI = 3'b111;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD_A = 3'd1,
      RD_B = 3'd2,
      EXEC = 3'd3,
      WB   = 3'd4
   } state_t;

   state_t state_r;
   state_t next_s;

   logic [2:0]        op_r;
   logic [ADDR_W-1:0] src_b_r;
   logic [ADDR_W-1:0] dst_r;
   logic [DATA_W-1:0] imm_r;
   logic [DATA_W-1:0] opa_r;
   logic [DATA_W-1:0] opb_r;

   logic [DATA_W-1:0] result_r;
   logic              zero_r;
   logic              carry_r;
   logic [ADDR_W-1:0] rf_raddr_r;
   logic              rf_we_r;
   logic [ADDR_W-1:0] rf_waddr_r;
   logic [DATA_W-1:0] rf_wdata_r;
   logic              busy_r;
   logic              done_r;

   logic [DATA_W:0]   alu_s;
   logic [ADDR_W-1:0] raddr_nx_s;

   // Returns {carry, result}; carry is the ADD carry-out or the SUB borrow.
   function automatic logic [DATA_W:0] alu_eval(
      input logic [2:0]        f_op,
      input logic [DATA_W-1:0] f_a,
      input logic [DATA_W-1:0] f_b,
      input logic [DATA_W-1:0] f_imm
   );
      logic [DATA_W:0] r;
      case (f_op)
         OP_ADD:  r = {1'b0, f_a} + {1'b0, f_b};
         OP_SUB:  r = {(f_a < f_b), f_a - f_b};
         OP_AND:  r = {1'b0, f_a & f_b};
         OP_OR:   r = {1'b0, f_a | f_b};
         OP_XOR:  r = {1'b0, f_a ^ f_b};
         OP_SLL:  r = {1'b0, f_a << f_b[SH_W-1:0]};
         OP_SRL:  r = {1'b0, f_a >> f_b[SH_W-1:0]};
         OP_LDI:  r = {1'b0, f_imm};
         default: r = '0;
      endcase
      return r;
   endfunction

   // Next-state logic for the read/read/execute/writeback sequence.
   always_comb begin
      next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) next_s = RD_A;
            else       next_s = IDLE;
         end
         RD_A:    next_s = RD_B;
         RD_B:    next_s = EXEC;
         EXEC:    next_s = WB;
         WB:      next_s = IDLE;
         default: next_s = IDLE;
      endcase
   end

   // ALU result and the read address for the coming cycle (port is registered).
   always_comb begin
      alu_s = alu_eval(op_r, opa_r, opb_r, imm_r);
      if (next_s == RD_A)      raddr_nx_s = src_a;
      else if (next_s == RD_B) raddr_nx_s = src_b_r;
      else                     raddr_nx_s = '0;
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_r <= IDLE;
      else          state_r <= next_s;
   end

   // Instruction latch and operand capture from the combinational read port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_r    <= 3'b000;
         src_b_r <= '0;
         dst_r   <= '0;
         imm_r   <= '0;
         opa_r   <= '0;
         opb_r   <= '0;
      end else begin
         if (state_r == IDLE && start) begin
            op_r    <= op;
            src_b_r <= src_b;
            dst_r   <= dst;
            imm_r   <= imm;
         end
         if (state_r == RD_A) opa_r <= rf_rData;
         if (state_r == RD_B) opb_r <= rf_rData;
      end
   end

   // Registered outputs; write-port address/data and flags hold between ops.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         result_r   <= '0;
         zero_r     <= 1'b0;
         carry_r    <= 1'b0;
         rf_raddr_r <= '0;
         rf_we_r    <= 1'b0;
         rf_waddr_r <= '0;
         rf_wdata_r <= '0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         rf_raddr_r <= raddr_nx_s;
         rf_we_r    <= (next_s == WB);
         busy_r     <= (next_s != IDLE);
         done_r     <= (state_r == WB);
         if (state_r == EXEC) begin
            result_r   <= alu_s[DATA_W-1:0];
            zero_r     <= (alu_s[DATA_W-1:0] == '0);
            carry_r    <= alu_s[DATA_W];
            rf_waddr_r <= dst_r;
            rf_wdata_r <= alu_s[DATA_W-1:0];
         end
      end
   end

   assign rf_rAddr = rf_raddr_r;
   assign rf_we    = rf_we_r;
   assign rf_wAddr = rf_waddr_r;
   assign rf_wData = rf_wdata_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign result   = result_r;
   assign zero     = zero_r;
   assign carry    = carry_r;

endmodule

// File: tb/tb_rf_alu_sequencer.sv
// Bench for rf_alu_sequencer: register-file environment, transaction-level
// reference model with per-cycle comparison, directed literals, random traffic.
module tb_rf_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [2:0]  src_a = 3'd0;
   logic [2:0]  src_b = 3'd0;
   logic [2:0]  dst = 3'd0;
   logic [31:0] imm = 32'd0;
   logic [2:0]  rf_rAddr;
   logic [31:0] rf_rData;
   logic        rf_we;
   logic [2:0]  rf_wAddr;
   logic [31:0] rf_wData;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        zero;
   logic        carry;

   int n_checks = 0;
   int n_fail = 0;
   logic chk_en = 1'b0;

   rf_alu_sequencer #(.DATA_W(32), .ADDR_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op),
      .src_a(src_a), .src_b(src_b), .dst(dst), .imm(imm),
      .rf_rAddr(rf_rAddr), .rf_rData(rf_rData), .rf_we(rf_we),
      .rf_wAddr(rf_wAddr), .rf_wData(rf_wData), .busy(busy), .done(done),
      .result(result), .zero(zero), .carry(carry)
   );

   always #5 clk = ~clk;

   // Register file the sequencer drives.
   logic [31:0] rf [0:7] = '{default: 32'h0};
   assign rf_rData = rf[rf_rAddr];
   always @(posedge clk) if (rf_we) rf[rf_wAddr] <= rf_wData;

   // Reference ALU: returns {carry, result}.
   function automatic logic [32:0] ref_alu(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] im);
      logic [63:0] wide;
      case (o)
         3'd0: wide = {32'd0, a} + {32'd0, b};
         3'd1: wide = {31'd0, (a < b), a - b};
         3'd2: wide = {32'd0, a & b};
         3'd3: wide = {32'd0, a | b};
         3'd4: wide = {32'd0, a ^ b};
         3'd5: wide = {32'd0, a << b[4:0]};
         3'd6: wide = {32'd0, a >> b[4:0]};
         default: wide = {32'd0, im};
      endcase
      return wide[32:0];
   endfunction

   // Transaction model: phase counts cycles since an accepted start (0 = idle).
   int          m_phase;
   logic        m_done, m_zero, m_carry;
   logic [2:0]  m_op, m_a, m_b, m_d, m_waddr;
   logic [31:0] m_imm, m_res, m_wdata;
   logic [31:0] m_rf [0:7] = '{default: 32'h0};
   logic [32:0] m_calc;
   assign m_calc = ref_alu(m_op, m_rf[m_a], m_rf[m_b], m_imm);

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase <= 0; m_done <= 1'b0; m_res <= 32'd0; m_zero <= 1'b0;
         m_carry <= 1'b0; m_waddr <= 3'd0; m_wdata <= 32'd0;
         m_op <= 3'd0; m_a <= 3'd0; m_b <= 3'd0; m_d <= 3'd0; m_imm <= 32'd0;
      end else begin
         m_done <= (m_phase == 4);
         if (m_phase == 0) begin
            if (start) begin
               m_phase <= 1; m_op <= op; m_a <= src_a; m_b <= src_b;
               m_d <= dst; m_imm <= imm;
            end
         end else if (m_phase == 3) begin
            m_res <= m_calc[31:0]; m_wdata <= m_calc[31:0]; m_waddr <= m_d;
            m_zero <= (m_calc[31:0] == 32'd0); m_carry <= m_calc[32];
            m_phase <= 4;
         end else if (m_phase == 4) begin
            m_rf[m_d] <= m_wdata;
            m_phase <= 0;
         end else begin
            m_phase <= m_phase + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (reset_n && chk_en) begin
         check("busy", {31'd0, busy}, {31'd0, m_phase != 0});
         check("rf_we", {31'd0, rf_we}, {31'd0, m_phase == 4});
         check("done", {31'd0, done}, {31'd0, m_done});
         check("rf_rAddr", {29'd0, rf_rAddr},
               {29'd0, (m_phase == 1) ? m_a : (m_phase == 2) ? m_b : 3'd0});
         check("rf_wAddr", {29'd0, rf_wAddr}, {29'd0, m_waddr});
         check("rf_wData", rf_wData, m_wdata);
         check("result", result, m_res);
         check("zero", {31'd0, zero}, {31'd0, m_zero});
         check("carry", {31'd0, carry}, {31'd0, m_carry});
      end
   end

   // Issue one op at the current negedge and wait (bounded) for done.
   task automatic do_op(input logic [2:0] o, input logic [2:0] a, input logic [2:0] b,
                        input logic [2:0] d, input logic [31:0] im);
      int n;
      op = o; src_a = a; src_b = b; dst = d; imm = im; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 1;
      while (done !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("latency", n, 32'd5);
   endtask

   initial begin
      #1 start = 1'b1;
      #5;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_we", {31'd0, rf_we}, 32'd0);
      check("rst_raddr", {29'd0, rf_rAddr}, 32'd0);
      check("rst_waddr", {29'd0, rf_wAddr}, 32'd0);
      check("rst_wdata", rf_wData, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_zero", {31'd0, zero}, 32'd0);
      check("rst_carry", {31'd0, carry}, 32'd0);
      start = 1'b0;
      #1 reset_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      check("idle_after_rst", {31'd0, busy}, 32'd0);

      do_op(3'd7, 3'd0, 3'd0, 3'd1, 32'h1111_0000);
      check("ldi1_wdata", rf_wData, 32'h1111_0000);
      check("ldi1_waddr", {29'd0, rf_wAddr}, 32'd1);
      do_op(3'd7, 3'd3, 3'd4, 3'd2, 32'hABCD_1234);
      check("ldi2_wdata", rf_wData, 32'hABCD_1234);
      do_op(3'd0, 3'd1, 3'd2, 3'd3, 32'd0);
      check("add_res", result, 32'hBCDE_1234);
      check("add_carry", {31'd0, carry}, 32'd0);
      check("add_zero", {31'd0, zero}, 32'd0);
      do_op(3'd1, 3'd1, 3'd1, 3'd4, 32'd0);
      check("sub0_res", result, 32'd0);
      check("sub0_zero", {31'd0, zero}, 32'd1);
      check("sub0_carry", {31'd0, carry}, 32'd0);
      do_op(3'd7, 3'd0, 3'd0, 3'd7, 32'hFFFF_FFFF);
      do_op(3'd7, 3'd0, 3'd0, 3'd0, 32'h0000_0001);
      do_op(3'd0, 3'd7, 3'd0, 3'd7, 32'd0);
      check("addc_res", result, 32'd0);
      check("addc_carry", {31'd0, carry}, 32'd1);
      check("addc_zero", {31'd0, zero}, 32'd1);
      do_op(3'd6, 3'd1, 3'd2, 3'd5, 32'd0);
      check("srl_res", result, 32'h0000_0111);
      do_op(3'd1, 3'd1, 3'd2, 3'd4, 32'd0);
      check("subb_res", result, 32'h6543_EDCC);
      check("subb_carry", {31'd0, carry}, 32'd1);

      // start held through a whole op: only one op runs
      op = 3'd7; dst = 3'd2; imm = 32'hABCD_1234; start = 1'b1;
      repeat (4) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("held_done", {31'd0, done}, 32'd1);
      @(negedge clk);
      check("held_single", {31'd0, busy}, 32'd0);

      // reset during RD_B aborts with no write
      do_op(3'd7, 3'd0, 3'd0, 3'd6, 32'h0000_0066);
      op = 3'd0; src_a = 3'd1; src_b = 3'd2; dst = 3'd6; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_we", {31'd0, rf_we}, 32'd0);
      #1 reset_n = 1'b1;
      @(negedge clk);
      do_op(3'd7, 3'd0, 3'd0, 3'd0, 32'h0000_00A5);
      check("abort_nowrite", rf[6], 32'h0000_0066);
      check("post_abort_ldi", rf[0], 32'h0000_00A5);

      // random traffic, including starts while busy
      repeat (1500) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         op = 3'($urandom);
         src_a = 3'($urandom);
         src_b = 3'($urandom);
         dst = 3'($urandom);
         case ($urandom_range(0, 3))
            0: imm = 32'd0;
            1: imm = 32'hFFFF_FFFF;
            default: imm = $urandom;
         endcase
      end
      start = 1'b0;
      repeat (8) @(negedge clk);
      for (int i = 0; i < 8; i++) check("rf_final", rf[i], m_rf[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
